fetch_ctrl: RTL and testbench

- Sequences the word-addressed, single-port instruction memory for the RISC-V core's IF stage.
- Owns the PC and issues one read per cycle at most.
- Buffers returned words in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for a word-addressed, single-port instruction
// memory. Owns the PC, issues at most one read per cycle under FIFO credit,
// buffers returned words and hands them to decode over valid/ready. Redirects
// flush buffered and in-flight fetches.
//
// Ports:
//   clk, rst_n      - core clock (posedge), async active-low reset
//   fetch_en        - permits issuing new fetches
//   imem_rd_en      - registered read enable to instruction memory
//   imem_addr       - registered word index (pc >> 2)
//   imem_instr      - read data, valid one posedge after the issuing posedge
//   if_valid        - FIFO head holds an instruction
//   if_instr/if_pc  - FIFO head instruction and its byte PC
//   id_ready        - decode accepts the head this cycle
//   redirect_valid  - load redirect_pc and flush
//   redirect_pc     - new byte PC, bits [1:0] ignored
//   busy            - a fetch is in flight or the FIFO is non-empty
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned USE_W = CNT_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             rd_en_q, rd_en_d;
  logic [31:0]      addr_q, addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] instr_mem_q [FIFO_DEPTH];
  logic [31:0] pc_mem_q    [FIFO_DEPTH];

  logic             push_c;
  logic             pop_c;
  logic [USE_W-1:0] used_c;
  logic             can_issue_c;
  logic [31:0]      redir_pc_c;

  // Circular pointer increment that also handles non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_c      = inflight_q;
  assign pop_c       = if_valid & id_ready;
  // Slots already committed: buffered + in flight, less the one decode frees now.
  assign used_c      = USE_W'(count_q) + USE_W'(inflight_q) - USE_W'(pop_c);
  assign can_issue_c = (used_c < USE_W'(FIFO_DEPTH));
  assign redir_pc_c  = redirect_pc & 32'hFFFF_FFFC;

  // Next-state: FSM, PC, issue and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_en_d       = 1'b0;
    addr_d        = addr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    state_d = fetch_en ? ST_RUN : ST_IDLE;

    if (redirect_valid) begin
      // Flush wins; the response landing this edge is dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (fetch_en || (state_q == ST_RUN)) begin
        rd_en_d       = 1'b1;
        addr_d        = redirect_pc >> 2;
        pc_d          = redir_pc_c + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = redir_pc_c;
      end else begin
        pc_d = redir_pc_c;
      end
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      // Issue only while staying in or entering RUN; a RUN->IDLE edge issues nothing.
      if (fetch_en && can_issue_c) begin
        rd_en_d       = 1'b1;
        addr_d        = pc_q >> 2;
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
    end
  end

  // Control and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_en_q       <= rd_en_d;
      addr_q        <= addr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push_c && !redirect_valid) begin
      instr_mem_q[wr_ptr_q] <= imem_instr;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_rd_en = rd_en_q;
  assign imem_addr  = addr_q;
  assign if_valid   = (count_q != '0);
  // Head is zeroed when empty so stale entries never leak out.
  assign if_instr   = if_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign busy       = inflight_q | if_valid;

`ifndef SYNTHESIS
  // Credit accounting must make a push into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && !pop_c && !redirect_valid && (count_q == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus hand-written
// reset sequences. Memory model returns a hash of the word address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'hDEAD_BEEF;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory samples on negedge; data holds when not read.
  always @(negedge clk) begin
    if (imem_rd_en) imem_instr <= mem_word(imem_addr);
  end

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        rd_en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        busy;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic rd,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic b);
    vec_t t;
    t.fe = fe; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.rd_en = rd;
    t.addr = addr; t.valid = v; t.pc = pc; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Stream from reset, 5-cycle stall, redirects, fetch_en drop, PC wrap.
    vecs[0]  = mk(1,1,0,0,             1,32'h40,1'b0,0,1);
    vecs[1]  = mk(1,1,0,0,             1,32'h41,1'b1,32'h100,1);
    vecs[2]  = mk(1,1,0,0,             1,32'h42,1'b1,32'h104,1);
    vecs[3]  = mk(1,1,0,0,             1,32'h43,1'b1,32'h108,1);
    vecs[4]  = mk(1,0,0,0,             0,32'h43,1'b1,32'h108,1);
    vecs[5]  = mk(1,0,0,0,             0,32'h43,1'b1,32'h108,1);
    vecs[6]  = mk(1,0,0,0,             0,32'h43,1'b1,32'h108,1);
    vecs[7]  = mk(1,0,0,0,             0,32'h43,1'b1,32'h108,1);
    vecs[8]  = mk(1,0,0,0,             0,32'h43,1'b1,32'h108,1);
    vecs[9]  = mk(1,1,0,0,             1,32'h44,1'b1,32'h10C,1);
    vecs[10] = mk(1,1,0,0,             1,32'h45,1'b1,32'h110,1);
    vecs[11] = mk(1,1,0,0,             1,32'h46,1'b1,32'h114,1);
    vecs[12] = mk(1,0,1,32'h203,       1,32'h80,1'b0,0,1);
    vecs[13] = mk(1,1,0,0,             1,32'h81,1'b1,32'h200,1);
    vecs[14] = mk(1,1,0,0,             1,32'h82,1'b1,32'h204,1);
    vecs[15] = mk(1,0,0,0,             0,32'h82,1'b1,32'h204,1);
    vecs[16] = mk(1,1,1,32'h300,       1,32'hC0,1'b0,0,1);
    vecs[17] = mk(1,1,0,0,             1,32'hC1,1'b1,32'h300,1);
    vecs[18] = mk(0,1,0,0,             0,32'hC1,1'b1,32'h304,1);
    vecs[19] = mk(0,1,0,0,             0,32'hC1,1'b0,0,0);
    vecs[20] = mk(0,1,0,0,             0,32'hC1,1'b0,0,0);
    vecs[21] = mk(1,1,0,0,             1,32'hC2,1'b0,0,1);
    vecs[22] = mk(1,1,0,0,             1,32'hC3,1'b1,32'h308,1);
    vecs[23] = mk(0,1,1,32'h40C,       1,32'h103,1'b0,0,1);
    vecs[24] = mk(0,0,0,0,             0,32'h103,1'b1,32'h40C,1);
    vecs[25] = mk(0,0,1,32'h501,       0,32'h103,1'b0,0,0);
    vecs[26] = mk(1,1,0,0,             1,32'h140,1'b0,0,1);
    vecs[27] = mk(1,1,0,0,             1,32'h141,1'b1,32'h500,1);
    vecs[28] = mk(1,1,1,32'hFFFF_FFFE, 1,32'h3FFF_FFFF,1'b0,0,1);
    vecs[29] = mk(1,1,0,0,             1,32'h0,1'b1,32'hFFFF_FFFC,1);
    vecs[30] = mk(1,1,0,0,             1,32'h1,1'b1,32'h0,1);

    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset rd_en", 32'(imem_rd_en), 32'h0);
    check("reset addr",  imem_addr,       32'h0);
    check("reset valid", 32'(if_valid),   32'h0);
    check("reset instr", if_instr,        32'h0);
    check("reset pc",    if_pc,           32'h0);
    check("reset busy",  32'(busy),       32'h0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      fetch_en       = vecs[i].fe;
      id_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("step%0d rd_en", i), 32'(imem_rd_en), 32'(vecs[i].rd_en));
      check($sformatf("step%0d addr", i),  imem_addr,       vecs[i].addr);
      check($sformatf("step%0d valid", i), 32'(if_valid),   32'(vecs[i].valid));
      check($sformatf("step%0d busy", i),  32'(busy),       32'(vecs[i].busy));
      if (vecs[i].valid) begin
        check($sformatf("step%0d if_pc", i),    if_pc,    vecs[i].pc);
        check($sformatf("step%0d if_instr", i), if_instr, mem_word(vecs[i].pc >> 2));
      end
    end

    // Async reset between edges with a read in flight.
    fetch_en       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rd_en", 32'(imem_rd_en), 32'h0);
    check("async addr",  imem_addr,       32'h0);
    check("async valid", 32'(if_valid),   32'h0);
    check("async instr", if_instr,        32'h0);
    check("async pc",    if_pc,           32'h0);
    check("async busy",  32'(busy),       32'h0);
    @(posedge clk);
    #1;
    check("held rd_en", 32'(imem_rd_en), 32'h0);
    check("held busy",  32'(busy),       32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post rst rd_en", 32'(imem_rd_en), 32'h1);
    check("post rst addr",  imem_addr,       32'h40);
    check("post rst valid", 32'(if_valid),   32'h0);
    @(posedge clk);
    #1;
    check("post rst valid1", 32'(if_valid), 32'h1);
    check("post rst pc1",    if_pc,         32'h100);
    check("post rst instr1", if_instr,      mem_word(32'h40));
    check("post rst addr1",  imem_addr,     32'h41);
    @(posedge clk);
    #1;
    check("post rst pc2",    if_pc,         32'h104);
    check("post rst instr2", if_instr,      mem_word(32'h41));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
